irq_arb: RTL and testbench

Platform-level external-interrupt arbiter that sits in front of the `csr` block and drives its active-low `ei` input. It gathers up to 8 level-sensitive peripheral interrupt lines and gates each one, so a source cannot re-pend while it is in service. It picks the highest-priority enabled pending source above a programmable threshold. Software uses a claim/complete handshake through a small register port, reached from the M-mode trap handler after `mcause` = 0x8000000b.

---
 rtl/irq_arb.sv | 144 ++++++++++++++
 tb/tb_irq_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arb.sv
// External-interrupt arbiter: per-source gateways, priority/threshold selection
// and a claim/complete register port driving the active-low ei line.
module irq_arb #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic             cfg_re,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             cfg_rvalid,
  output logic             ei
);

  localparam logic [2:0] A_ENABLE    = 3'd0;
  localparam logic [2:0] A_PENDING   = 3'd1;
  localparam logic [2:0] A_THRESHOLD = 3'd2;
  localparam logic [2:0] A_CLAIM     = 3'd3;
  localparam logic [2:0] A_PRIORITY  = 3'd4;
  localparam logic [2:0] A_INSERVICE = 3'd5;

  logic [N_SRC-1:0]      enable_q, enable_d;
  logic [N_SRC-1:0]      pending_q, pending_d;
  logic [N_SRC-1:0]      inservice_q, inservice_d;
  logic [2:0]            thresh_q, thresh_d;
  logic [N_SRC-1:0][2:0] prio_q, prio_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q;
  logic                  ei_q;

  logic [3:0]            best_id;
  logic [2:0]            best_prio;
  logic                  claim;
  logic                  wr_en;
  logic [N_SRC-1:0]      complete_hit;
  logic [31:0]           rd_mux;

  assign claim = cfg_re && (cfg_addr == A_CLAIM);
  assign wr_en = cfg_we;

  // Strict '>' keeps the lowest ID on equal priorities; any eligible
  // source has prio >= 1, so the zero start value never wins.
  always_comb begin
    best_id   = 4'd0;
    best_prio = 3'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q) &&
          (prio_q[i] > best_prio)) begin
        best_id   = 4'(i + 1);
        best_prio = prio_q[i];
      end
    end
  end

  // IDs 0 and > N_SRC match no bit, and clearing an idle bit is a no-op.
  always_comb begin
    complete_hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      complete_hit[i] = wr_en && (cfg_addr == A_CLAIM) &&
                        (cfg_wdata[3:0] == 4'(i + 1));
    end
  end

  always_comb begin
    pending_d   = pending_q | (~src & ~inservice_q);
    inservice_d = inservice_q & ~complete_hit;
    // Claim is applied after complete so a same-ID pair leaves it in service.
    if (claim && (best_id != 4'd0)) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (best_id == 4'(i + 1)) begin
          pending_d[i]   = 1'b0;
          inservice_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    if (wr_en) begin
      case (cfg_addr)
        A_ENABLE:    enable_d = cfg_wdata[N_SRC-1:0];
        A_THRESHOLD: thresh_d = cfg_wdata[2:0];
        A_PRIORITY: begin
          for (int i = 0; i < N_SRC; i++) begin
            prio_d[i] = cfg_wdata[4*i +: 3];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      A_ENABLE:    rd_mux[N_SRC-1:0] = enable_q;
      A_PENDING:   rd_mux[N_SRC-1:0] = pending_q;
      A_THRESHOLD: rd_mux[2:0]       = thresh_q;
      A_CLAIM:     rd_mux[3:0]       = best_id;
      A_PRIORITY: begin
        for (int i = 0; i < N_SRC; i++) begin
          rd_mux[4*i +: 3] = prio_q[i];
        end
      end
      A_INSERVICE: rd_mux[N_SRC-1:0] = inservice_q;
      default:     rd_mux = '0;
    endcase
  end

  assign rdata_d = cfg_re ? rd_mux : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q    <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      thresh_q    <= '0;
      prio_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ei_q        <= 1'b1;
    end else begin
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      thresh_q    <= thresh_d;
      prio_q      <= prio_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= cfg_re;
      ei_q        <= (best_id == 4'd0);
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign ei         = ei_q;

endmodule

// File: tb/tb_irq_arb.sv
// Randomized and directed bench for irq_arb against a behavioural model of
// the gateway / priority / claim-complete rules.
module tb_irq_arb;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] src = '1;
  logic        cfg_re = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic        ei;

  always #5 clk = ~clk;

  irq_arb #(.N_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n), .src(src),
    .cfg_re(cfg_re), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cfg_rvalid(cfg_rvalid), .ei(ei)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  bit m_en[N];
  bit m_pend[N];
  bit m_ins[N];
  int m_pr[N];
  int m_thr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_ins[i] = 0; m_pr[i] = 0;
    end
    m_thr = 0;
  endfunction

  // Scan priority levels from the top; the first eligible ID found at a level wins.
  function automatic int model_best();
    for (int p = 7; p >= 1; p--)
      for (int id = 1; id <= N; id++)
        if (m_pend[id-1] && m_en[id-1] && m_pr[id-1] == p && p > m_thr) return id;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a, input int b);
    logic [31:0] r = '0;
    case (a)
      3'd0: for (int i = 0; i < N; i++) r[i] = m_en[i];
      3'd1: for (int i = 0; i < N; i++) r[i] = m_pend[i];
      3'd2: r = 32'(m_thr);
      3'd3: r = 32'(b);
      3'd4: for (int i = 0; i < N; i++) r = r + (32'(m_pr[i]) << (4 * i));
      3'd5: for (int i = 0; i < N; i++) r[i] = m_ins[i];
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: predict from current inputs and model state, advance, compare.
  task automatic step();
    int b;
    int id;
    bit n_pend[N];
    bit n_ins[N];
    logic exp_ei;
    logic re_was;
    b = model_best();
    n_pend = m_pend;
    n_ins = m_ins;
    for (int i = 0; i < N; i++)
      if (!src[i] && !m_ins[i]) n_pend[i] = 1;
    re_was = cfg_re;
    if (cfg_re) exp_q.push_back(model_read(cfg_addr, b));
    if (cfg_we) begin
      case (cfg_addr)
        3'd0: for (int i = 0; i < N; i++) m_en[i] = cfg_wdata[i];
        3'd2: m_thr = int'(cfg_wdata[2:0]);
        3'd3: begin
          id = int'(cfg_wdata[3:0]);
          if (id >= 1 && id <= N) n_ins[id-1] = 0;
        end
        3'd4: for (int i = 0; i < N; i++) m_pr[i] = int'(cfg_wdata[4*i +: 3]);
        default: ;
      endcase
    end
    if (cfg_re && cfg_addr == 3'd3 && b != 0) begin
      n_pend[b-1] = 0;
      n_ins[b-1] = 1;
    end
    exp_ei = (b == 0);
    @(posedge clk);
    #1;
    m_pend = n_pend;
    m_ins = n_ins;
    check("ei", ei, exp_ei);
    check("rvalid", cfg_rvalid, re_was);
    if (re_was && exp_q.size() > 0) check("rdata", cfg_rdata, exp_q.pop_front());
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 0;
  endtask

  task automatic cfg_rd(input logic [2:0] a, output logic [31:0] d);
    cfg_re = 1; cfg_addr = a;
    step();
    cfg_re = 0;
    d = cfg_rdata;
  endtask

  initial begin
    logic [31:0] d;
    int op;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ei", ei, 1);
    check("rst_rvalid", cfg_rvalid, 0);
    check("rst_rdata", cfg_rdata, 0);
    rst_n = 1;

    // Single source: pend, ei, claim, complete with source still low
    cfg_wr(3'd0, 32'h01);
    cfg_wr(3'd4, 32'h1);
    cfg_wr(3'd2, 32'h0);
    src[0] = 0;
    step();
    cfg_rd(3'd1, d);  check("pend_src1", d, 32'h01);
    check("ei_src1", ei, 0);
    cfg_rd(3'd3, d);  check("claim_src1", d, 32'd1);
    step();           check("ei_after_claim", ei, 1);
    cfg_rd(3'd5, d);  check("insvc_src1", d, 32'h01);
    cfg_wr(3'd3, 32'd1);
    step();
    step();           check("ei_repend", ei, 0);
    cfg_rd(3'd3, d);  check("claim_src1_again", d, 32'd1);
    src[0] = 1;
    cfg_wr(3'd3, 32'd1);

    // Priority ordering: IDs 2 and 5 at prio 3, ID 7 at prio 2
    cfg_wr(3'd4, 32'h0203_0030);
    cfg_wr(3'd0, 32'h52);
    src = 8'hAD;
    step();
    src = 8'hFF;
    step();
    cfg_rd(3'd3, d);  check("claim_a", d, 32'd2);
    cfg_rd(3'd3, d);  check("claim_b", d, 32'd5);
    cfg_rd(3'd3, d);  check("claim_c", d, 32'd7);
    cfg_rd(3'd3, d);  check("claim_none", d, 32'd0);
    check("ei_all_claimed", ei, 1);
    cfg_wr(3'd3, 32'd2);
    cfg_wr(3'd3, 32'd5);
    cfg_wr(3'd3, 32'd7);

    // Threshold equal to priority blocks, lower threshold releases
    cfg_wr(3'd0, 32'h04);
    cfg_wr(3'd4, 32'h300);
    cfg_wr(3'd2, 32'd3);
    src = 8'hFB;
    step();
    src = 8'hFF;
    step();
    step();           check("ei_thr_block", ei, 1);
    cfg_rd(3'd3, d);  check("claim_thr_block", d, 32'd0);
    cfg_rd(3'd1, d);  check("pend_thr_block", d, 32'h04);
    cfg_wr(3'd2, 32'd2);
    step();           check("ei_thr_release", ei, 0);

    // Ignored completes
    cfg_wr(3'd3, 32'd9);
    cfg_wr(3'd3, 32'd0);
    cfg_wr(3'd3, 32'd4);
    cfg_rd(3'd5, d);  check("insvc_ignored", d, 32'h0);
    cfg_rd(3'd1, d);  check("pend_ignored", d, 32'h04);

    // Claim and complete of ID 3 in one cycle
    cfg_re = 1; cfg_we = 1; cfg_addr = 3'd3; cfg_wdata = 32'd3;
    step();
    cfg_re = 0; cfg_we = 0;
    check("claim_cc", cfg_rdata, 32'd3);
    cfg_rd(3'd5, d);  check("insvc_cc", d, 32'h04);
    cfg_wr(3'd3, 32'd3);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      src = N'($urandom);
      op = $urandom_range(0, 9);
      case (op)
        3, 4: begin cfg_re = 1; cfg_addr = 3'($urandom_range(0, 7)); end
        5: begin cfg_re = 1; cfg_addr = 3'd3; end
        6: begin cfg_we = 1; cfg_addr = 3'd3; cfg_wdata = 32'($urandom_range(0, 9)); end
        7: begin cfg_we = 1; cfg_addr = 3'($urandom_range(0, 7)); cfg_wdata = $urandom; end
        8: begin cfg_we = 1; cfg_addr = 3'd2; cfg_wdata = 32'($urandom_range(0, 3)); end
        9: begin
          cfg_re = 1; cfg_we = 1; cfg_addr = 3'd3;
          cfg_wdata = 32'($urandom_range(1, 8));
        end
        default: ;
      endcase
      step();
      cfg_re = 0; cfg_we = 0;
    end

    // Reset in the middle of activity
    src = 8'hFF;
    cfg_wr(3'd0, 32'hFF);
    cfg_wr(3'd4, 32'h7777_7777);
    cfg_wr(3'd2, 32'd0);
    src = 8'h00;
    step();
    cfg_rd(3'd5, d);
    check("ei_before_rst", ei, 0);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_ei", ei, 1);
    check("mid_rst_rvalid", cfg_rvalid, 0);
    check("mid_rst_rdata", cfg_rdata, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    step();
    cfg_rd(3'd1, d);  check("pend_after_rst", d, 32'hFF);
    cfg_rd(3'd0, d);  check("en_after_rst", d, 32'h0);
    cfg_rd(3'd4, d);  check("prio_after_rst", d, 32'h0);
    cfg_rd(3'd5, d);  check("insvc_after_rst", d, 32'h0);
    step();           check("ei_after_rst", ei, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
